mem_1r1w_bank_resp: RTL and testbench
=====================================

MEM_1R1W_BANK_RESP -- requirements
Module: mem_1r1w_bank_resp

Interface
REQ-001 The block SHALL have parameter PHYWDTH, default 64, physical row width in bits.
REQ-002 The block SHALL have parameter NUMSROW, default 1024, number of physical rows.
REQ-003 The block SHALL have parameter BITSROW, default 10, row address width.
REQ-004 The block SHALL have parameter DELAY, default 1, read latency in cycles; legal range 1..4.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have the port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have the port writeA, input, 1 bit: write strobe for port A.
REQ-008 The block SHALL have the port addrA, input, BITSROW bits: write row address.
REQ-009 The block SHALL have the port dinA, input, PHYWDTH bits: write data.
REQ-010 The block SHALL have the port bwA, input, PHYWDTH bits: per-bit write enable.
REQ-011 The block SHALL have the port readB, input, 1 bit: read strobe for port B.
REQ-012 The block SHALL have the port addrB, input, BITSROW bits: read row address.
REQ-013 The block SHALL have the port doutB, output, PHYWDTH bits: read data.
REQ-014 The block SHALL have the port doutB_vld, output, 1 bit: doutB carries read data this cycle.
REQ-015 The block SHALL have the port ready, output, 1 bit: the bank accepts accesses.
REQ-016 The block SHALL have the port adr_err, output, 1 bit: sticky flag, set by an out-of-range access.

Function
REQ-017 The block SHALL update the addressed row as new = (old & ~bwA) | (dinA & bwA) on a rising clk edge where writeA=1, ready=1 and addrA<NUMSROW.
REQ-018 The block SHALL present the row addressed by addrB on doutB, with doutB_vld=1, exactly DELAY cycles after a rising edge where readB=1 and ready=1.
REQ-019 The read pipeline SHALL accept one read per cycle back-to-back with no bubbles.
REQ-020 In cycles where doutB_vld=0, doutB SHALL hold its last driven value.
REQ-021 For a read and a write to the same row on the same edge, the read SHALL return the pre-write contents (read-before-write).
REQ-022 A write on edge N SHALL be visible to a read issued on edge N+1.
REQ-023 An access with addr>=NUMSROW SHALL leave the memory unchanged; a read to such an address SHALL return all-zero data with doutB_vld=1; either SHALL set adr_err, which stays 1 until reset.
REQ-024 The block SHALL ignore writeA and readB while ready=0; no pipeline entry is created and memory is not modified.
REQ-025 Init FSM states SHALL be: RST (in reset), INIT (sweep), RDY.
REQ-026 The FSM SHALL go from RST to INIT on the first edge after reset release.
REQ-027 In INIT the block SHALL zero one row per cycle, counter 0..NUMSROW-1, and SHALL go to RDY after row NUMSROW-1 is written.
REQ-028 ready SHALL be 1 only in RDY.
REQ-029 The sweep counter SHALL be BITSROW+1 bits wide so the terminal count does not wrap when NUMSROW=2^BITSROW.

Reset
REQ-030 Asserting rst low SHALL force FSM=RST, counter=0, ready=0, doutB_vld=0 (all pipeline valid stages cleared), doutB=0 and adr_err=0, immediately and independent of clk.
REQ-031 A reset asserted during INIT or RDY SHALL discard in-flight reads and SHALL restart the sweep on release.

Configuration
REQ-032 With macro MEM_INIT_CLEAR_EN defined, the block SHALL perform the INIT sweep per REQ-027.
REQ-033 With MEM_INIT_CLEAR_EN undefined, INIT SHALL be skipped, the FSM SHALL go RST to RDY on the first edge after reset release, memory contents SHALL be unspecified until written, and no sweep counter is built.

Verification
REQ-034 The bench SHALL cover init: with MEM_INIT_CLEAR_EN, NUMSROW=1024, release rst -> ready rises 1025 edges after release; then a read of row 1023 returns 0 with doutB_vld.
REQ-035 The bench SHALL cover a masked write: row 5 = 0xFFFF_FFFF_FFFF_FFFF, then write dinA=0, bwA=0x0000_0000_FFFF_FFFF, then read row 5 -> 0xFFFF_FFFF_0000_0000.
REQ-036 The bench SHALL cover a collision: row 7 = 0xA, then write 0xB to row 7 and read row 7 on the same edge -> 0xA after DELAY cycles; a read on the next edge -> 0xB.
REQ-037 The bench SHALL cover latency: DELAY=3, reads to rows 1,2,3 on consecutive edges -> doutB_vld high for 3 consecutive cycles starting 3 cycles after the first read, data in order.
REQ-038 The bench SHALL cover an address error: NUMSROW=1000, BITSROW=10, write to addrA=1010 -> no row changes, adr_err=1 and stays 1 until rst is asserted.
REQ-039 The bench SHALL cover reset mid-read: DELAY=2, issue a read, assert rst the next cycle -> doutB_vld never rises for that read and ready=0 immediately.

Source files
------------

// File: rtl/mem_1r1w_bank_resp.sv
// 1R1W row memory: per-bit masked writes, DELAY-cycle read pipeline, sticky address error.
// Optional post-reset zeroing sweep is built when MEM_INIT_CLEAR_EN is defined.
module mem_1r1w_bank_resp #(
    parameter int PHYWDTH = 64,
    parameter int NUMSROW = 1024,
    parameter int BITSROW = 10,
    parameter int DELAY   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               writeA,
    input  logic [BITSROW-1:0] addrA,
    input  logic [PHYWDTH-1:0] dinA,
    input  logic [PHYWDTH-1:0] bwA,
    input  logic               readB,
    input  logic [BITSROW-1:0] addrB,
    output logic [PHYWDTH-1:0] doutB,
    output logic               doutB_vld,
    output logic               ready,
    output logic               adr_err
);
    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RDY  = 2'd2;
    // One extra bit so NUMSROW == 2^BITSROW is representable.
    localparam logic [BITSROW:0] ROWS = (BITSROW+1)'(NUMSROW);

    logic [1:0]                    state;
    logic [PHYWDTH-1:0]            mem [NUMSROW];
    logic                          wrFire, rdFire, wrInRange, rdInRange;
    logic [PHYWDTH-1:0]            rdRow;
    logic [DELAY:1]                vldPipe;
    logic [DELAY:1][PHYWDTH-1:0]   dataPipe;

    assign ready     = (state == ST_RDY);
    assign wrInRange = ({1'b0, addrA} < ROWS);
    assign rdInRange = ({1'b0, addrB} < ROWS);
    assign wrFire    = writeA & ready;
    assign rdFire    = readB & ready;
    assign rdRow     = rdInRange ? mem[addrB] : '0;

`ifdef MEM_INIT_CLEAR_EN
    localparam logic [BITSROW:0] LASTROW = (BITSROW+1)'(NUMSROW - 1);
    logic [BITSROW:0] sweepCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RST;
            sweepCnt <= '0;
        end else begin
            case (state)
                ST_RST:  state <= ST_INIT;
                ST_INIT: begin
                    sweepCnt <= sweepCnt + 1'b1;
                    if (sweepCnt == LASTROW) state <= ST_RDY;
                end
                default: state <= ST_RDY;
            endcase
        end
    end

    // Sweep owns the write port until ready; user writes cannot fire then anyway.
    always_ff @(posedge clk) begin
        if (state == ST_INIT)
            mem[sweepCnt[BITSROW-1:0]] <= '0;
        else if (wrFire && wrInRange)
            mem[addrA] <= (mem[addrA] & ~bwA) | (dinA & bwA);
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RST;
        end else begin
            case (state)
                ST_RST, ST_INIT: state <= ST_RDY;
                default:         state <= ST_RDY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wrFire && wrInRange)
            mem[addrA] <= (mem[addrA] & ~bwA) | (dinA & bwA);
    end
`endif

    // Row is sampled on the issuing edge, so a same-edge write is not seen (read-before-write).
    // Each data stage loads only behind a valid, which makes doutB hold between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vldPipe  <= '0;
            dataPipe <= '0;
        end else begin
            vldPipe[1] <= rdFire;
            if (rdFire) dataPipe[1] <= rdRow;
            for (int k = 2; k <= DELAY; k++) begin
                vldPipe[k] <= vldPipe[k-1];
                if (vldPipe[k-1]) dataPipe[k] <= dataPipe[k-1];
            end
        end
    end

    assign doutB     = dataPipe[DELAY];
    assign doutB_vld = vldPipe[DELAY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            adr_err <= 1'b0;
        else if ((wrFire && !wrInRange) || (rdFire && !rdInRange))
            adr_err <= 1'b1;
    end
endmodule

// File: tb/tb_mem_1r1w_bank_resp.sv
// Bench for mem_1r1w_bank_resp: three instances (DELAY 1/3/2, one with 1000 rows) sharing
// request inputs; instances not under test are held in reset so they ignore traffic.
module tb_mem_1r1w_bank_resp;
    localparam int W      = 64;
    localparam int DLY_B  = 3;
    localparam int ROWS_B = 1000;
    localparam logic [W-1:0] ONES = '1;
`ifdef MEM_INIT_CLEAR_EN
    localparam int INIT_A = 1025;
    localparam int INIT_B = 1001;
    localparam int INIT_C = 1025;
`else
    localparam int INIT_A = 1;
    localparam int INIT_B = 1;
    localparam int INIT_C = 1;
`endif

    typedef struct {
        logic         wr;
        logic [9:0]   wa;
        logic [W-1:0] din;
        logic [W-1:0] bw;
        logic [9:0]   ra;
        logic [W-1:0] exp;
    } vec_t;

    typedef struct {
        int           due;
        logic [W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rstA, rstB, rstC;
    logic writeA, readB;
    logic [9:0] addrA, addrB;
    logic [W-1:0] dinA, bwA;
    logic [W-1:0] dout [3];
    logic vld [3];
    logic rdy [3];
    logic err [3];

    int nTests = 0;
    int nFail = 0;
    int edgeCnt = 0;
    vec_t vecs [9];
    exp_t q [$];
    logic [W-1:0] mdl [16];

    always #5 clk = ~clk;

    mem_1r1w_bank_resp dutA (
        .clk(clk), .rst(rstA), .writeA(writeA), .addrA(addrA), .dinA(dinA), .bwA(bwA),
        .readB(readB), .addrB(addrB), .doutB(dout[0]), .doutB_vld(vld[0]),
        .ready(rdy[0]), .adr_err(err[0]));

    mem_1r1w_bank_resp #(.PHYWDTH(W), .NUMSROW(ROWS_B), .BITSROW(10), .DELAY(DLY_B)) dutB (
        .clk(clk), .rst(rstB), .writeA(writeA), .addrA(addrA), .dinA(dinA), .bwA(bwA),
        .readB(readB), .addrB(addrB), .doutB(dout[1]), .doutB_vld(vld[1]),
        .ready(rdy[1]), .adr_err(err[1]));

    mem_1r1w_bank_resp #(.DELAY(2)) dutC (
        .clk(clk), .rst(rstC), .writeA(writeA), .addrA(addrA), .dinA(dinA), .bwA(bwA),
        .readB(readB), .addrB(addrB), .doutB(dout[2]), .doutB_vld(vld[2]),
        .ready(rdy[2]), .adr_err(err[2]));

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edgeCnt++;
    endtask

    task automatic waitReady(input int idx, input int expEdges, input string nm);
        int n;
        logic sawVld;
        n = 0;
        sawVld = 1'b0;
        while (rdy[idx] !== 1'b1 && n < 3000) begin
            tick();
            n++;
            if (vld[idx] !== 1'b0) sawVld = 1'b1;
        end
        check({nm, "_edges"}, W'(n), W'(expEdges));
        check({nm, "_novld"}, W'(sawVld), '0);
    endtask

    task automatic wrRow(input logic [9:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
        writeA = 1'b1; addrA = a; dinA = d; bwA = m;
        tick();
        writeA = 1'b0;
    endtask

    task automatic rdCheck(input int idx, input int dly, input logic [9:0] a,
                           input logic [W-1:0] exp, input string nm);
        readB = 1'b1; addrB = a;
        tick();
        readB = 1'b0;
        repeat (dly - 1) tick();
        check({nm, "_vld"}, W'(vld[idx]), W'(1));
        check(nm, dout[idx], exp);
    endtask

    function automatic logic [9:0] pickRow();
        if ($urandom_range(0, 7) == 0) return 10'($urandom_range(ROWS_B, 1023));
        return 10'($urandom_range(0, 15));
    endfunction

    task automatic scoreB();
        if (q.size() > 0 && q[0].due == edgeCnt) begin
            check("rnd_vld", W'(vld[1]), W'(1));
            check("rnd_data", dout[1], q[0].data);
            q.delete(0);
        end else begin
            check("rnd_idle", W'(vld[1]), '0);
        end
    endtask

    initial begin
        rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
        writeA = 1'b0; readB = 1'b0; addrA = '0; addrB = '0; dinA = '0; bwA = '0;

        vecs[0] = '{1'b1, 10'd20, 64'h1234_5678_9ABC_DEF0, ONES, 10'd20, 64'h1234_5678_9ABC_DEF0};
        vecs[1] = '{1'b1, 10'd20, 64'h0, 64'h00FF_00FF_00FF_00FF, 10'd20, 64'h1200_5600_9A00_DE00};
        vecs[2] = '{1'b1, 10'd21, ONES, ONES, 10'd21, ONES};
        vecs[3] = '{1'b1, 10'd21, 64'h0, 64'hF0F0_F0F0_F0F0_F0F0, 10'd21, 64'h0F0F_0F0F_0F0F_0F0F};
        vecs[4] = '{1'b1, 10'd20, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0, 10'd20, 64'h1200_5600_9A00_DE00};
        vecs[5] = '{1'b0, 10'd21, ONES, ONES, 10'd21, 64'h0F0F_0F0F_0F0F_0F0F};
        vecs[6] = '{1'b1, 10'd1023, 64'hDEAD_BEEF_0000_0001, ONES, 10'd1023, 64'hDEAD_BEEF_0000_0001};
        vecs[7] = '{1'b1, 10'd0, 64'h5, ONES, 10'd0, 64'h5};
        vecs[8] = '{1'b1, 10'd0, ONES, 64'h8000_0000_0000_0000, 10'd0, 64'h8000_0000_0000_0005};

        #2;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_rdy%0d", d), W'(rdy[d]), '0);
            check($sformatf("rst_vld%0d", d), W'(vld[d]), '0);
            check($sformatf("rst_dout%0d", d), dout[d], '0);
            check($sformatf("rst_err%0d", d), W'(err[d]), '0);
        end
        tick(); tick();

        // Instance A: init timing, table vectors, masked write, collision.
        rstA = 1'b1;
        waitReady(0, INIT_A, "initA");
`ifdef MEM_INIT_CLEAR_EN
        rdCheck(0, 1, 10'd1023, '0, "sweep_row1023");
`endif
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) wrRow(vecs[i].wa, vecs[i].din, vecs[i].bw);
            rdCheck(0, 1, vecs[i].ra, vecs[i].exp, $sformatf("vec%0d", i));
        end
        wrRow(10'd5, ONES, ONES);
        wrRow(10'd5, '0, 64'h0000_0000_FFFF_FFFF);
        rdCheck(0, 1, 10'd5, 64'hFFFF_FFFF_0000_0000, "masked_row5");

        wrRow(10'd7, 64'hA, ONES);
        writeA = 1'b1; addrA = 10'd7; dinA = 64'hB; bwA = ONES;
        readB = 1'b1; addrB = 10'd7;
        tick();
        writeA = 1'b0;
        check("coll_old_vld", W'(vld[0]), W'(1));
        check("coll_old", dout[0], 64'hA);
        tick();
        readB = 1'b0;
        check("coll_new_vld", W'(vld[0]), W'(1));
        check("coll_new", dout[0], 64'hB);
        tick();
        check("hold_after_read", dout[0], 64'hB);
        check("idle_vld", W'(vld[0]), '0);
        rstA = 1'b0;

        // Instance B: latency/back-to-back, address error, then random traffic.
        rstB = 1'b1;
        waitReady(1, INIT_B, "initB");
        wrRow(10'd1, 64'h111, ONES);
        wrRow(10'd2, 64'h222, ONES);
        wrRow(10'd3, 64'h333, ONES);
        readB = 1'b1; addrB = 10'd1;
        tick(); check("lat_e1_vld", W'(vld[1]), '0);
        addrB = 10'd2;
        tick(); check("lat_e2_vld", W'(vld[1]), '0);
        addrB = 10'd3;
        tick(); readB = 1'b0;
        check("lat_r1_vld", W'(vld[1]), W'(1)); check("lat_r1", dout[1], 64'h111);
        tick();
        check("lat_r2_vld", W'(vld[1]), W'(1)); check("lat_r2", dout[1], 64'h222);
        tick();
        check("lat_r3_vld", W'(vld[1]), W'(1)); check("lat_r3", dout[1], 64'h333);
        tick();
        check("lat_end_vld", W'(vld[1]), '0); check("lat_hold", dout[1], 64'h333);

        check("err_clear", W'(err[1]), '0);
        wrRow(10'd1010, '0, ONES);
        check("err_set", W'(err[1]), W'(1));
        tick(); tick();
        check("err_sticky", W'(err[1]), W'(1));
        rdCheck(1, DLY_B, 10'd1, 64'h111, "oor_keep1");
        rdCheck(1, DLY_B, 10'd2, 64'h222, "oor_keep2");
        rdCheck(1, DLY_B, 10'd3, 64'h333, "oor_keep3");
        rdCheck(1, DLY_B, 10'd1010, '0, "oor_read");
        check("err_still", W'(err[1]), W'(1));
        rstB = 1'b0;
        #1;
        check("err_rst", W'(err[1]), '0);
        check("rdy_rstB", W'(rdy[1]), '0);
        tick();

        rstB = 1'b1;
        waitReady(1, INIT_B, "reinitB");
        for (int i = 0; i < 16; i++) begin
            mdl[i] = {$urandom, $urandom};
            wrRow(10'(i), mdl[i], ONES);
        end
        for (int c = 0; c < 400; c++) begin
            logic doW, doR;
            logic [9:0] wa, ra;
            logic [W-1:0] d, m;
            doW = 1'($urandom_range(0, 1));
            doR = 1'($urandom_range(0, 1));
            wa = pickRow();
            ra = pickRow();
            d = {$urandom, $urandom};
            m = {$urandom, $urandom};
            writeA = doW; addrA = wa; dinA = d; bwA = m;
            readB = doR; addrB = ra;
            if (doR) q.push_back('{edgeCnt + DLY_B, (ra < ROWS_B) ? mdl[ra[3:0]] : '0});
            if (doW && wa < ROWS_B) mdl[wa[3:0]] = (mdl[wa[3:0]] & ~m) | (d & m);
            tick();
            scoreB();
        end
        writeA = 1'b0; readB = 1'b0;
        repeat (DLY_B + 1) begin
            tick();
            scoreB();
        end
        check("rnd_drained", W'(q.size()), '0);
        rstB = 1'b0;

        // Instance C: reset lands while a read is in flight.
        rstC = 1'b1;
        waitReady(2, INIT_C, "initC");
        wrRow(10'd4, 64'h44, ONES);
        readB = 1'b1; addrB = 10'd4;
        tick();
        readB = 1'b0;
        #2 rstC = 1'b0;
        #1;
        check("midrd_rdy", W'(rdy[2]), '0);
        check("midrd_vld", W'(vld[2]), '0);
        check("midrd_dout", dout[2], '0);
        tick();
        check("midrd_vld_e1", W'(vld[2]), '0);
        tick();
        check("midrd_vld_e2", W'(vld[2]), '0);
        rstC = 1'b1;
        waitReady(2, INIT_C, "reinitC");
`ifdef MEM_INIT_CLEAR_EN
        rdCheck(2, 2, 10'd4, '0, "resweep_row4");
`else
        rdCheck(2, 2, 10'd4, 64'h44, "postrst_row4");
`endif

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
